// File: rtl/rob_retire_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rob_retire_ctrl_pkg
// Shared widths, entry layout and flush-state encodings for the reorder
// buffer controller. The FRAT imports the same package so both ends of the
// allocate/retire interface agree on ROB id width.
// Optional feature macro: ROB_BYPASS_EN (bypass read ports on the interface).
// ---------------------------------------------------------------------------
package rob_retire_ctrl_pkg;

   localparam int ROB_SIZE        = 32;
   localparam int ROB_SIZE_CLOG   = $clog2(ROB_SIZE);
   localparam int ISSUE_WIDTH_MAX = 2;
   localparam int ROB_MAX_RETIRE  = 2;
   localparam int CDB_WIDTH       = 2;
   localparam int SRC_LEN         = 5;
   localparam int DATA_LEN        = 32;
   localparam int NUM_SRCS        = 2;
   // count must hold the value ROB_SIZE itself, hence one extra bit
   localparam int CNT_W           = ROB_SIZE_CLOG + 1;

   // Flush state machine encodings
   localparam logic [0:0] ROB_IDLE  = 1'b0;
   localparam logic [0:0] ROB_FLUSH = 1'b1;

   typedef logic [ROB_SIZE_CLOG-1:0] rob_id_t;

   typedef struct packed {
      logic                valid;
      logic                done;
      logic                no_rd;
      logic                mispredict;
      logic [SRC_LEN-1:0]  rd;
      logic [DATA_LEN-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// ---------------------------------------------------------------------------
// rob_retire_ctrl_if
// Bundles the ROB's decode-allocate, CDB-completion and retire buses.
//   master : the surrounding pipeline (decode, CDB, retire consumer)
//   slave  : the ROB controller
// Handshake semantics: there is no backpressure beyond rob_full. A decode
// lane allocates on a clock edge iff instr_val_id[l]=1 and rob_full=0 in that
// cycle (all-or-nothing); a CDB lane is consumed on every edge where
// cdb_val[k]=1; a retire lane is valid for exactly the cycle val_ret[j]=1.
// Optional feature macro: ROB_BYPASS_EN adds byp_robid/byp_data/byp_rdy.
// ---------------------------------------------------------------------------
interface rob_retire_ctrl_if;
   import rob_retire_ctrl_pkg::*;

   // allocation
   logic [ISSUE_WIDTH_MAX-1:0]               instr_val_id;
   logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]  rd_id;
   logic [ISSUE_WIDTH_MAX-1:0]               no_rd_id;
   logic [ROB_SIZE_CLOG-1:0]                 rob_is_ptr;
   logic [ROB_SIZE_CLOG-1:0]                 rob_is_ptr_p1;
   logic                                     rob_full;
   // completion
   logic [CDB_WIDTH-1:0]                     cdb_val;
   logic [CDB_WIDTH-1:0][ROB_SIZE_CLOG-1:0]  cdb_robid;
   logic [CDB_WIDTH-1:0][DATA_LEN-1:0]       cdb_data;
   logic [CDB_WIDTH-1:0]                     cdb_mispredict;
   // retire / flush
   logic [ROB_MAX_RETIRE-1:0]                val_ret;
   logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]   rd_ret;
   logic [ROB_MAX_RETIRE-1:0]                branch_ret;
   logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0]  data_ret;
   logic                                     branch_clear_id;
   logic [ROB_SIZE_CLOG-1:0]                 mispredict_tag_id;
`ifdef ROB_BYPASS_EN
   logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][ROB_SIZE_CLOG-1:0] byp_robid;
   logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0][DATA_LEN-1:0]      byp_data;
   logic [ISSUE_WIDTH_MAX-1:0][NUM_SRCS-1:0]                    byp_rdy;
`endif

   modport master (
      output instr_val_id, rd_id, no_rd_id,
      output cdb_val, cdb_robid, cdb_data, cdb_mispredict,
      input  rob_is_ptr, rob_is_ptr_p1, rob_full,
      input  val_ret, rd_ret, branch_ret, data_ret,
      input  branch_clear_id, mispredict_tag_id
`ifdef ROB_BYPASS_EN
      , output byp_robid
      , input  byp_data, byp_rdy
`endif
   );

   modport slave (
      input  instr_val_id, rd_id, no_rd_id,
      input  cdb_val, cdb_robid, cdb_data, cdb_mispredict,
      output rob_is_ptr, rob_is_ptr_p1, rob_full,
      output val_ret, rd_ret, branch_ret, data_ret,
      output branch_clear_id, mispredict_tag_id
`ifdef ROB_BYPASS_EN
      , input  byp_robid
      , output byp_data, byp_rdy
`endif
   );

endinterface

// File: rtl/rob_retire_ctrl_sel.sv
// ---------------------------------------------------------------------------
// rob_retire_sel
// Combinational in-order retire selection over the window head..head+R-1.
//   win_valid/win_done/win_mis : per-lane entry state, lane 0 = head
//   ret_mask                   : contiguous prefix of lanes that may retire
//   mis_hit                    : a retiring lane carries a mispredict
// A mispredicted entry itself retires; every younger lane is held back so
// nothing past the bad branch ever reaches the retire bus.
// ---------------------------------------------------------------------------
module rob_retire_sel
   import rob_retire_ctrl_pkg::*;
(
   input  logic [ROB_MAX_RETIRE-1:0] win_valid,
   input  logic [ROB_MAX_RETIRE-1:0] win_done,
   input  logic [ROB_MAX_RETIRE-1:0] win_mis,
   output logic [ROB_MAX_RETIRE-1:0] ret_mask,
   output logic                      mis_hit
);

   logic chain;

   always_comb begin
      ret_mask = '0;
      mis_hit  = 1'b0;
      chain    = 1'b1;
      for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
         ret_mask[j] = chain & win_valid[j] & win_done[j];
         mis_hit     = mis_hit | (ret_mask[j] & win_mis[j]);
         chain       = ret_mask[j] & ~win_mis[j];
      end
   end

endmodule

// File: rtl/rob_retire_ctrl.sv
// ---------------------------------------------------------------------------
// rob_retire_ctrl
// Reorder buffer controller: allocates entries for decode lanes, marks them
// done from the CDB, retires them in order and raises a one-cycle flush when
// a mispredicted branch retires.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rob_if     : slave side of rob_retire_ctrl_if (alloc, CDB, retire, flush)
//   state_dbg  : current flush-FSM state (ROB_IDLE / ROB_FLUSH)
// Optional feature macro: ROB_BYPASS_EN adds combinational operand-bypass
// reads (byp_robid -> byp_data/byp_rdy) with same-cycle CDB forwarding.
// ---------------------------------------------------------------------------
module rob_retire_ctrl
   import rob_retire_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   rob_retire_ctrl_if.slave rob_if,
   output logic [0:0]       state_dbg
);

   localparam logic [CNT_W-1:0] ROB_SIZE_CNT = CNT_W'(ROB_SIZE);
   localparam logic [CNT_W-1:0] ISSUE_CNT    = CNT_W'(ISSUE_WIDTH_MAX);

   rob_entry_t ent_q [ROB_SIZE];
   rob_entry_t ent_d [ROB_SIZE];
   rob_id_t    head_q, head_d, tail_q, tail_d, tag_q, tag_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [0:0] state_q, state_d;

   logic [ROB_MAX_RETIRE-1:0]               val_ret_q, val_ret_d;
   logic [ROB_MAX_RETIRE-1:0]               branch_ret_q, branch_ret_d;
   logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]  rd_ret_q, rd_ret_d;
   logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0] data_ret_q, data_ret_d;

   rob_id_t                   win_idx [ROB_MAX_RETIRE];
   logic [ROB_MAX_RETIRE-1:0] win_valid, win_done, win_mis;
   logic [ROB_MAX_RETIRE-1:0] sel_mask, ret_go;
   logic                      sel_mis, mis_go, full;
   logic [CNT_W-1:0]          nalloc, nret;

   // ---------------- retire window ----------------
   always_comb begin
      for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
         win_idx[j]   = head_q + rob_id_t'(j);
         win_valid[j] = ent_q[win_idx[j]].valid;
         win_done[j]  = ent_q[win_idx[j]].done;
         win_mis[j]   = ent_q[win_idx[j]].mispredict;
      end
   end

   rob_retire_sel u_sel (
      .win_valid (win_valid),
      .win_done  (win_done),
      .win_mis   (win_mis),
      .ret_mask  (sel_mask),
      .mis_hit   (sel_mis)
   );

   // Nothing retires while the flush is being applied.
   assign ret_go = (state_q == ROB_IDLE) ? sel_mask : '0;
   assign mis_go = (state_q == ROB_IDLE) & sel_mis;

   // Allocation is also blocked in the cycle the bad branch retires, so no
   // younger instruction slips in ahead of the flush.
   assign full = ((ROB_SIZE_CNT - count_q) < ISSUE_CNT) | (state_q == ROB_FLUSH) | mis_go;

   // ---------------- next state ----------------
   always_comb begin
      ent_d        = ent_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      state_d      = state_q;
      tag_d        = tag_q;
      val_ret_d    = '0;
      branch_ret_d = '0;
      rd_ret_d     = '0;
      data_ret_d   = '0;
      nalloc       = '0;
      nret         = '0;

      if (state_q == ROB_FLUSH) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            ent_d[i].valid = 1'b0;
         end
         tail_d  = head_q;
         count_d = '0;
         state_d = ROB_IDLE;
      end else begin
         // retire
         for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
            if (ret_go[j]) begin
               val_ret_d[j]              = 1'b1;
               rd_ret_d[j]               = ent_q[win_idx[j]].rd;
               branch_ret_d[j]           = ent_q[win_idx[j]].no_rd;
               data_ret_d[j]             = ent_q[win_idx[j]].data;
               ent_d[win_idx[j]].valid   = 1'b0;
               nret                      = nret + CNT_W'(1);
               if (ent_q[win_idx[j]].mispredict) begin
                  tag_d = win_idx[j];
               end
            end
         end
         head_d = head_q + rob_id_t'(nret);

         // completion; writes to empty slots are dropped
         for (int k = 0; k < CDB_WIDTH; k++) begin
            if (rob_if.cdb_val[k] && ent_q[rob_if.cdb_robid[k]].valid) begin
               ent_d[rob_if.cdb_robid[k]].done       = 1'b1;
               ent_d[rob_if.cdb_robid[k]].data       = rob_if.cdb_data[k];
               ent_d[rob_if.cdb_robid[k]].mispredict = rob_if.cdb_mispredict[k];
            end
         end

         // allocation, valid lanes compacted in lane order from tail
         if (!full) begin
            for (int l = 0; l < ISSUE_WIDTH_MAX; l++) begin
               if (rob_if.instr_val_id[l]) begin
                  ent_d[tail_q + rob_id_t'(nalloc)] = '{valid: 1'b1, done: 1'b0,
                                                        no_rd: rob_if.no_rd_id[l],
                                                        mispredict: 1'b0,
                                                        rd: rob_if.rd_id[l],
                                                        data: '0};
                  nalloc = nalloc + CNT_W'(1);
               end
            end
         end
         tail_d  = tail_q + rob_id_t'(nalloc);
         count_d = count_q + nalloc - nret;

         if (mis_go) begin
            state_d = ROB_FLUSH;
         end
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            ent_q[i] <= '0;
         end
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         state_q      <= ROB_IDLE;
         tag_q        <= '0;
         val_ret_q    <= '0;
         branch_ret_q <= '0;
         rd_ret_q     <= '0;
         data_ret_q   <= '0;
      end else begin
         ent_q        <= ent_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         state_q      <= state_d;
         tag_q        <= tag_d;
         val_ret_q    <= val_ret_d;
         branch_ret_q <= branch_ret_d;
         rd_ret_q     <= rd_ret_d;
         data_ret_q   <= data_ret_d;
      end
   end

   // ---------------- outputs ----------------
   assign rob_if.rob_is_ptr        = tail_q;
   assign rob_if.rob_is_ptr_p1     = tail_q + rob_id_t'(1);
   assign rob_if.rob_full          = full;
   assign rob_if.val_ret           = val_ret_q;
   assign rob_if.rd_ret            = rd_ret_q;
   assign rob_if.branch_ret        = branch_ret_q;
   assign rob_if.data_ret          = data_ret_q;
   assign rob_if.branch_clear_id   = (state_q == ROB_FLUSH);
   assign rob_if.mispredict_tag_id = tag_q;
   assign state_dbg                = state_q;

`ifdef ROB_BYPASS_EN
   // Operand bypass: stored result if done, else a same-cycle CDB hit.
   rob_id_t byp_id;

   always_comb begin
      rob_if.byp_data = '0;
      rob_if.byp_rdy  = '0;
      byp_id          = '0;
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
         for (int s = 0; s < NUM_SRCS; s++) begin
            byp_id                = rob_if.byp_robid[i][s];
            rob_if.byp_data[i][s] = ent_q[byp_id].data;
            rob_if.byp_rdy[i][s]  = ent_q[byp_id].valid & ent_q[byp_id].done;
            for (int k = 0; k < CDB_WIDTH; k++) begin
               if (rob_if.cdb_val[k] && (rob_if.cdb_robid[k] == byp_id) &&
                   ent_q[byp_id].valid && (state_q == ROB_IDLE)) begin
                  rob_if.byp_data[i][s] = rob_if.cdb_data[k];
                  rob_if.byp_rdy[i][s]  = 1'b1;
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_retire_ctrl
// Directed bench for rob_retire_ctrl: a table of per-cycle vectors with
// hand-computed expectations, then hand-written sequences for full, wrap and
// mid-flight reset.
// ---------------------------------------------------------------------------
module tb_rob_retire_ctrl;
   import rob_retire_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] state_dbg;

   rob_retire_ctrl_if u_if ();

   rob_retire_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .rob_if    (u_if.slave),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [1:0]  iv;   logic [4:0] rd0;  logic [4:0] rd1; logic [1:0] nrd;
      logic [1:0]  cv;   logic [4:0] cid0; logic [31:0] cd0;
      logic [4:0]  cid1; logic [31:0] cd1; logic [1:0] cmis;
      logic [4:0]  e_ptr; logic e_full; logic [1:0] e_vret;
      logic [4:0]  e_rd0; logic [4:0] e_rd1; logic [1:0] e_bret;
      logic [31:0] e_d0;  logic [31:0] e_d1;
      logic        e_clr; logic [4:0] e_tag; logic e_st;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(
      input logic [1:0] iv, input logic [4:0] rd0, input logic [4:0] rd1, input logic [1:0] nrd,
      input logic [1:0] cv, input logic [4:0] cid0, input logic [31:0] cd0,
      input logic [4:0] cid1, input logic [31:0] cd1, input logic [1:0] cmis,
      input logic [4:0] e_ptr, input logic e_full, input logic [1:0] e_vret,
      input logic [4:0] e_rd0, input logic [4:0] e_rd1, input logic [1:0] e_bret,
      input logic [31:0] e_d0, input logic [31:0] e_d1,
      input logic e_clr, input logic [4:0] e_tag, input logic e_st);
      vec_t v;
      v.iv = iv; v.rd0 = rd0; v.rd1 = rd1; v.nrd = nrd;
      v.cv = cv; v.cid0 = cid0; v.cd0 = cd0; v.cid1 = cid1; v.cd1 = cd1; v.cmis = cmis;
      v.e_ptr = e_ptr; v.e_full = e_full; v.e_vret = e_vret;
      v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bret = e_bret;
      v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_clr = e_clr; v.e_tag = e_tag; v.e_st = e_st;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      u_if.instr_val_id   = '0;
      u_if.rd_id          = '0;
      u_if.no_rd_id       = '0;
      u_if.cdb_val        = '0;
      u_if.cdb_robid      = '0;
      u_if.cdb_data       = '0;
      u_if.cdb_mispredict = '0;
   endtask

   task automatic drive_alloc(input logic [1:0] iv, input logic [4:0] rd0,
                              input logic [4:0] rd1, input logic [1:0] nrd);
      u_if.instr_val_id = iv;
      u_if.rd_id[0]     = rd0;
      u_if.rd_id[1]     = rd1;
      u_if.no_rd_id     = nrd;
   endtask

   task automatic drive_cdb(input logic [1:0] cv, input logic [4:0] id0, input logic [31:0] d0,
                            input logic [4:0] id1, input logic [31:0] d1, input logic [1:0] mis);
      u_if.cdb_val        = cv;
      u_if.cdb_robid[0]   = id0;
      u_if.cdb_data[0]    = d0;
      u_if.cdb_robid[1]   = id1;
      u_if.cdb_data[1]    = d1;
      u_if.cdb_mispredict = mis;
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [4:0] p1;
      vec_t v;
      rst = 1'b1;
      drive_idle();

      //                iv     rd0 rd1 nrd    cv     cid0 cd0    cid1 cd1    cmis   ptr full vret  rd0 rd1 bret   d0     d1     clr tag st
      vecs[0]  = mk(2'b11, 5,  6, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 2, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[1]  = mk(2'b00, 0,  0, 2'b00, 2'b01, 1, 'h11,  0, 0,     2'b00, 2, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[2]  = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 2, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[3]  = mk(2'b00, 0,  0, 2'b00, 2'b01, 0, 'h10,  0, 0,     2'b00, 2, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[4]  = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 2, 0, 2'b11, 5, 6, 2'b00, 'h10,  'h11,  0, 0, 0);
      vecs[5]  = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 2, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[6]  = mk(2'b01, 7,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 3, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[7]  = mk(2'b11, 0,  9, 2'b01, 2'b01, 2, 'h22,  0, 0,     2'b00, 5, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 0, 0);
      vecs[8]  = mk(2'b00, 0,  0, 2'b00, 2'b11, 3, 'h33,  4, 'h44,  2'b01, 5, 1, 2'b01, 7, 0, 2'b00, 'h22,  0,     0, 0, 0);
      vecs[9]  = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 5, 1, 2'b01, 0, 0, 2'b01, 'h33,  0,     1, 3, 1);
      vecs[10] = mk(2'b11, 10, 11, 2'b00, 2'b01, 4, 'h55, 0, 0,     2'b00, 4, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 3, 0);
      vecs[11] = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 4, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 3, 0);
      vecs[12] = mk(2'b01, 12, 0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 5, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 3, 0);
      vecs[13] = mk(2'b00, 0,  0, 2'b00, 2'b01, 4, 'h66,  0, 0,     2'b00, 5, 0, 2'b00, 0, 0, 2'b00, 0,     0,     0, 3, 0);
      vecs[14] = mk(2'b00, 0,  0, 2'b00, 2'b00, 0, 0,     0, 0,     2'b00, 5, 0, 2'b01, 12, 0, 2'b00, 'h66, 0,     0, 3, 0);

      // ---------------- reset state ----------------
      do_reset();
      check("rst_ptr",   u_if.rob_is_ptr, 0);
      check("rst_ptr1",  u_if.rob_is_ptr_p1, 1);
      check("rst_full",  u_if.rob_full, 0);
      check("rst_vret",  u_if.val_ret, 0);
      check("rst_rd",    u_if.rd_ret, 0);
      check("rst_bret",  u_if.branch_ret, 0);
      check("rst_data",  u_if.data_ret, 0);
      check("rst_clr",   u_if.branch_clear_id, 0);
      check("rst_tag",   u_if.mispredict_tag_id, 0);
      check("rst_state", state_dbg, 0);

      // ---------------- table: alloc, out-of-order completion, mispredict flush ----------------
      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         drive_idle();
         drive_alloc(v.iv, v.rd0, v.rd1, v.nrd);
         drive_cdb(v.cv, v.cid0, v.cd0, v.cid1, v.cd1, v.cmis);
         step();
         p1 = v.e_ptr + 5'd1;
         check($sformatf("v%0d_ptr", i),   u_if.rob_is_ptr, v.e_ptr);
         check($sformatf("v%0d_ptr1", i),  u_if.rob_is_ptr_p1, p1);
         check($sformatf("v%0d_full", i),  u_if.rob_full, v.e_full);
         check($sformatf("v%0d_vret", i),  u_if.val_ret, v.e_vret);
         if (v.e_vret[0]) begin
            check($sformatf("v%0d_rd0", i),   u_if.rd_ret[0], v.e_rd0);
            check($sformatf("v%0d_bret0", i), u_if.branch_ret[0], v.e_bret[0]);
            check($sformatf("v%0d_d0", i),    u_if.data_ret[0], v.e_d0);
         end
         if (v.e_vret[1]) begin
            check($sformatf("v%0d_rd1", i),   u_if.rd_ret[1], v.e_rd1);
            check($sformatf("v%0d_bret1", i), u_if.branch_ret[1], v.e_bret[1]);
            check($sformatf("v%0d_d1", i),    u_if.data_ret[1], v.e_d1);
         end
         check($sformatf("v%0d_clr", i),   u_if.branch_clear_id, v.e_clr);
         check($sformatf("v%0d_tag", i),   u_if.mispredict_tag_id, v.e_tag);
         check($sformatf("v%0d_state", i), state_dbg, v.e_st);
      end

      // ---------------- full: 31 in flight blocks, one retire frees ----------------
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive_idle();
         drive_alloc(2'b11, 5'(2 * i), 5'(2 * i + 1), 2'b00);
         step();
      end
      check("full30_ptr", u_if.rob_is_ptr, 30);
      check("full30_full", u_if.rob_full, 0);
      drive_idle();
      drive_alloc(2'b01, 30, 0, 2'b00);
      step();
      check("full31_ptr", u_if.rob_is_ptr, 31);
      check("full31_full", u_if.rob_full, 1);
      drive_idle();
      drive_alloc(2'b11, 1, 2, 2'b00);
      step();
      check("blocked_ptr", u_if.rob_is_ptr, 31);
      drive_idle();
      drive_cdb(2'b01, 0, 'hC0, 0, 0, 2'b00);
      step();
      check("full_done_full", u_if.rob_full, 1);
      check("full_done_vret", u_if.val_ret, 0);
      drive_idle();
      step();
      check("full_ret_vret", u_if.val_ret, 2'b01);
      check("full_ret_data", u_if.data_ret[0], 'hC0);
      check("full_ret_full", u_if.rob_full, 0);

      // ---------------- wrap: head at 30, ids 30,31,0,1 ----------------
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive_idle();
         drive_alloc(2'b11, 0, 0, 2'b00);
         step();
      end
      for (int i = 0; i < 15; i++) begin
         drive_idle();
         drive_cdb(2'b11, 5'(2 * i), 32'(2 * i), 5'(2 * i + 1), 32'(2 * i + 1), 2'b00);
         step();
      end
      drive_idle();
      step();
      step();
      step();
      check("wrap_head_ptr", u_if.rob_is_ptr, 30);
      check("wrap_empty_vret", u_if.val_ret, 0);
      drive_alloc(2'b11, 1, 2, 2'b00);
      step();
      check("wrap_ptr0", u_if.rob_is_ptr, 0);
      drive_alloc(2'b11, 3, 4, 2'b00);
      step();
      check("wrap_ptr2", u_if.rob_is_ptr, 2);
      drive_idle();
      drive_cdb(2'b11, 1, 'hA1, 0, 'hA0, 2'b00);
      step();
      check("wrap_young_vret", u_if.val_ret, 0);
      drive_idle();
      drive_cdb(2'b11, 30, 'hB0, 31, 'hB1, 2'b00);
      step();
      check("wrap_old_vret", u_if.val_ret, 0);
      drive_idle();
      step();
      check("wrap_r1_vret", u_if.val_ret, 2'b11);
      check("wrap_r1_rd0", u_if.rd_ret[0], 1);
      check("wrap_r1_rd1", u_if.rd_ret[1], 2);
      check("wrap_r1_d0", u_if.data_ret[0], 'hB0);
      check("wrap_r1_d1", u_if.data_ret[1], 'hB1);
      step();
      check("wrap_r2_vret", u_if.val_ret, 2'b11);
      check("wrap_r2_rd0", u_if.rd_ret[0], 3);
      check("wrap_r2_rd1", u_if.rd_ret[1], 4);
      check("wrap_r2_d0", u_if.data_ret[0], 'hA0);
      check("wrap_r2_d1", u_if.data_ret[1], 'hA1);
      step();
      check("wrap_r3_vret", u_if.val_ret, 0);

      // ---------------- reset with 10 entries in flight ----------------
      for (int i = 0; i < 5; i++) begin
         drive_idle();
         drive_alloc(2'b11, 5'(i + 8), 5'(i + 16), 2'b00);
         step();
      end
      check("mid_ptr", u_if.rob_is_ptr, 12);
      drive_idle();
      drive_cdb(2'b01, 2, 'hDD, 0, 0, 2'b00);
      step();
      drive_idle();
      rst = 1'b1;
      step();
      check("mid_rst_vret", u_if.val_ret, 0);
      check("mid_rst_ptr", u_if.rob_is_ptr, 0);
      check("mid_rst_full", u_if.rob_full, 0);
      check("mid_rst_clr", u_if.branch_clear_id, 0);
      rst = 1'b0;
      step();
      check("mid_post_vret", u_if.val_ret, 0);
      check("mid_post_ptr", u_if.rob_is_ptr, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rob_retire_ctrl.md
Name: rob_retire_ctrl

Overview:
- Reorder buffer controller: the other end of the f_rat allocate/retire interface.
- Allocates ROB entries for up to ISSUE_WIDTH_MAX decoded instructions per cycle and drives rob_is_ptr, rob_is_ptr_p1 and rob_full to the FRAT.
- Marks entries done from the CDB and retires up to ROB_MAX_RETIRE entries per cycle in order on the retire bus (rd_ret, val_ret, branch_ret).
- On a mispredicted branch reaching retirement, raises branch_clear_id and mispredict_tag_id.

Parameters:
- ROB_SIZE, 32, number of entries; power of two.
- ROB_SIZE_CLOG, $clog2(ROB_SIZE), ROB id width.
- ISSUE_WIDTH_MAX, 2, allocation lanes.
- ROB_MAX_RETIRE, 2, retire lanes.
- CDB_WIDTH, 2, completion lanes.
- SRC_LEN, 5, architectural register index width.
- DATA_LEN, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_val_id  in  ISSUE_WIDTH_MAX  valid instruction per decode lane.
- rd_id  in  ISSUE_WIDTH_MAX x SRC_LEN  destination register.
- no_rd_id  in  ISSUE_WIDTH_MAX  1 = branch/store, no register write.
- rob_is_ptr  out  ROB_SIZE_CLOG  id for the first valid allocating lane (tail).
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  tail+1 mod ROB_SIZE.
- rob_full  out  1  allocation blocked.
- cdb_val  in  CDB_WIDTH  completion valid.
- cdb_robid  in  CDB_WIDTH x ROB_SIZE_CLOG  completing entry.
- cdb_data  in  CDB_WIDTH x DATA_LEN  result.
- cdb_mispredict  in  CDB_WIDTH  completing branch mispredicted.
- val_ret  out  ROB_MAX_RETIRE  retire lane valid.
- rd_ret  out  ROB_MAX_RETIRE x SRC_LEN  retiring destination.
- branch_ret  out  ROB_MAX_RETIRE  retiring entry has no register write.
- data_ret  out  ROB_MAX_RETIRE x DATA_LEN  retiring result.
- branch_clear_id  out  1  flush pulse.
- mispredict_tag_id  out  ROB_SIZE_CLOG  ROB id of the mispredicted branch.

Behaviour:
- **State:** circular array of entries {valid, done, no_rd, mispredict, rd, data}; registers head, tail and count (ROB_SIZE_CLOG+1 bits).
- **rob_full:** combinational; asserted when ROB_SIZE-count < ISSUE_WIDTH_MAX, or while a flush is pending/active. Allocation is all-or-nothing per cycle.
- **Allocation:** when ~rob_full, valid lanes are compacted in lane order.
  - The first valid lane takes tail; the second takes tail+1.
  - This matches the FRAT rule: lane1 id = instr_val_id[0] ? rob_is_ptr_p1 : rob_is_ptr.
  - Entries are written valid=1, done=0 on the clock edge; tail advances by popcount(instr_val_id).
- **Completion:** cdb_val[k] sets done, data and mispredict of entry cdb_robid[k] on the edge. Writes to an entry with valid=0 are ignored.
- **Retire select:** combinational from head.
  - Lane j is eligible iff entries head..head+j are all valid and done.
  - Every lane after a mispredicted entry is suppressed.
- **Retire bus:** registered. The edge that advances head loads val_ret, rd_ret, branch_ret=no_rd and data_ret for the selected entries and clears their valid bit; lanes not retiring output val_ret=0.
- **Latency:** CDB write at edge N gives done in cycle N+1 and val_ret high in cycle N+2 (head entry, nothing older pending).
- **count update:** count <= count + nalloc - nret in the same edge.
- **Wrap-around:** all pointer arithmetic is mod ROB_SIZE.
- **Empty:** count==0 means no retire; val_ret=0.
- **Flush state machine:** states IDLE -> FLUSH -> IDLE.
  - Retiring a mispredicted entry moves IDLE->FLUSH and latches mispredict_tag_id.
  - In FLUSH: branch_clear_id=1 for exactly one cycle, all valid bits are cleared, tail<=head, count<=0, CDB writes are ignored, and allocation is blocked; then return to IDLE.
- **Reset:** all valid=0, head=tail=count=0, state IDLE. Outputs: rob_is_ptr=0, rob_is_ptr_p1=1, rob_full=0, val_ret=0, rd_ret=0, branch_ret=0, data_ret=0, branch_clear_id=0, mispredict_tag_id=0. Reset mid-operation discards all entries with no retire.

Optional Feature:
- **ROB_BYPASS_EN:**
  - **Defined:** adds inputs byp_robid (ISSUE_WIDTH_MAX x NUM_SRCS x ROB_SIZE_CLOG) and outputs byp_data (DATA_LEN each) and byp_rdy (1 each). Reads are combinational from the entry; byp_rdy = valid & done. A same-cycle CDB write to the read id forwards cdb_data with byp_rdy=1.
  - **Undefined:** these ports are absent, and data is still stored for data_ret.

Decomposition:
- **Shared package** (alongside rtl_constants.sv): rob_entry_t struct, ROB_SIZE_CLOG, and the flush-state enum {ROB_IDLE, ROB_FLUSH}; the FRAT imports the same widths.
- **Sub-module rob_retire_sel:** combinational; takes head-window valid/done/mispredict vectors and returns a retire lane mask plus a mispredict-hit flag.

Test Plan:
- Reset, then 2 allocations in one cycle (rd 5, 6) -> ids 0, 1; rob_is_ptr=2 in the next cycle.
- CDB completes id 1 then id 0 -> no retire until id 0 is done; then val_ret=2'b11, rd_ret={6,5} in one cycle.
- 31 entries allocated -> rob_full=1 (1 free < 2); retire 1 -> rob_full=0.
- Wrap: head=30, allocate 4 -> ids 30, 31, 0, 1; retire order preserved.
- Branch id 3 completes with cdb_mispredict and id 4 is done -> lane0 retires 3 with branch_ret=1, id 4 is suppressed; next cycle branch_clear_id=1 and mispredict_tag_id=3; then count=0 and tail=head=4.
- Assert rst with 10 entries in flight -> next cycle val_ret=0, rob_is_ptr=0, rob_full=0.
